seg_display_scheduler: RTL and testbench

Time-shares the single 7-segment output among NUM_SRC nibble sources, typically counter digits, using round-robin selection with a programmable dwell time. Dwell is timed by an internal clock-enable tick generator, so the whole block runs on clk with no derived clock. It drives the registered segment pattern plus the selected index, and sits between the counter blocks and the top-level uo_out mapping.

---
 rtl/seg_display_scheduler.sv | 148 ++++++++++++++
 tb/tb_seg_display_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of one 7-segment display among NUM_SRC nibble sources.
// A clock-enable prescaler paces the dwell timer; everything runs on clk.
//
// state | meaning
// IDLE  | no source valid, display dark
// SHOW  | displaying src_data[sel_idx], dwell timer running on ticks
// BLANK | display dark until the next tick, then advance to the next valid source
module seg_display_scheduler #(
  parameter int NUM_SRC     = 4,
  parameter int PRESCALE    = 1000,
  parameter int DWELL_TICKS = 8,
  localparam int SEL_W      = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena_i,
  input  logic [4*NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]   src_valid_i,
  input  logic                 hold_i,
  output logic [6:0]           seg_out_o,
  output logic [SEL_W-1:0]     sel_idx_o,
  output logic                 tick_out_o,
  output logic                 switch_pulse_o
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic             pulse_q, pulse_d;
  logic             tick;
  logic             others_valid;
  logic [SEL_W-1:0] lowest_idx, next_idx;
  logic [3:0]       nib [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_nib
    assign nib[i] = src_data_i[4*i +: 4];
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Next valid index strictly after sel, wrapping; falls back to sel itself when it is the only one.
  function automatic logic [SEL_W-1:0] next_valid(input logic [NUM_SRC-1:0] v,
                                                   input logic [SEL_W-1:0] sel);
    logic [SEL_W-1:0] cand;
    next_valid = sel;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = SEL_W'((int'(sel) + k) % NUM_SRC);
      if (v[cand]) next_valid = cand;
    end
  endfunction

  // Prescaler tick and source-selection helpers.
  always_comb begin
    tick         = ena_i && (pre_q == PRE_LAST);
    pre_d        = pre_q;
    if (ena_i) pre_d = tick ? '0 : pre_q + PW'(1);
    others_valid = |(src_valid_i & ~(NUM_SRC'(1) << sel_q));
    lowest_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid_i[i]) lowest_idx = SEL_W'(i);
    end
    next_idx     = next_valid(src_valid_i, sel_q);
  end

  // Next-state, selection, dwell and registered-output decode.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (|src_valid_i) begin
          state_d = SHOW;
          sel_d   = lowest_idx;
          dwell_d = '0;
        end
      end
      SHOW: begin
        if (!src_valid_i[sel_q]) begin
          state_d = others_valid ? BLANK : IDLE;
          dwell_d = '0;
        end else if (tick && !hold_i) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (others_valid) state_d = BLANK;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end
      BLANK: begin
        if (tick) begin
          if (|src_valid_i) begin
            state_d = SHOW;
            sel_d   = next_idx;
            dwell_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pulse_d = (state_d == SHOW) && (state_q != SHOW);
    seg_d   = (state_d == SHOW) ? hex7(nib[sel_d]) : 7'h00;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      dwell_q <= '0;
      sel_q   <= '0;
      seg_q   <= 7'h00;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      pulse_q <= pulse_d;
    end
  end

  assign seg_out_o      = seg_q;
  assign sel_idx_o      = sel_q;
  assign tick_out_o     = tick;
  assign switch_pulse_o = pulse_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomized bench for seg_display_scheduler with a per-cycle behavioural reference.
module tb_seg_display_scheduler;

  localparam int N = 4;
  localparam int P = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [15:0]  data;
  logic [3:0]   valid;
  logic         hold;
  logic [6:0]   seg_out;
  logic [1:0]   sel_idx;
  logic         tick_out;
  logic         switch_pulse;

  seg_display_scheduler #(.NUM_SRC(N), .PRESCALE(P), .DWELL_TICKS(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena_i          (ena),
    .src_data_i     (data),
    .src_valid_i    (valid),
    .hold_i         (hold),
    .seg_out_o      (seg_out),
    .sel_idx_o      (sel_idx),
    .tick_out_o     (tick_out),
    .switch_pulse_o (switch_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: mode 0 = dark/idle, 1 = showing, 2 = blank gap.
  int         m_mode, m_sel, m_shown, m_phase, m_pulse_cnt, m_seen_ticks;
  logic [6:0] m_seg;
  logic       m_pulse;
  int         tick_seen, pulse_seen;
  logic [3:0] sel_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_shown = 0; m_phase = 0;
    m_seg = 7'h00; m_pulse = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, predict, then check after the rising edge.
  task automatic step(input logic e, input logic [3:0] v, input logic [15:0] d, input logic h);
    bit t;
    bit any_valid, others;
    int pick;
    ena = e; valid = v; data = d; hold = h;
    #1;
    t = e && (m_phase % P == P - 1);
    chk("tick", tick_out, t);
    if (tick_out) tick_seen++;
    if (e) m_phase++;
    any_valid = (v != 0);
    others = 0;
    for (int i = 0; i < N; i++) if (i != m_sel && v[i]) others = 1;
    m_pulse = 0;
    if (m_mode == 0) begin
      if (any_valid) begin
        for (int i = N - 1; i >= 0; i--) if (v[i]) m_sel = i;
        m_mode = 1; m_shown = 0; m_pulse = 1;
      end
    end else if (m_mode == 1) begin
      if (!v[m_sel]) begin
        m_mode = others ? 2 : 0; m_shown = 0;
      end else if (t && !h) begin
        m_shown++;
        if (m_shown == D) begin
          m_shown = 0;
          if (others) m_mode = 2;
        end
      end
    end else if (t) begin
      if (!any_valid) m_mode = 0;
      else begin
        pick = m_sel;
        for (int k = 1; k <= N; k++) if (v[(m_sel + k) % N] && pick == m_sel) pick = (m_sel + k) % N;
        if (!v[pick]) pick = m_sel;
        m_sel = pick; m_mode = 1; m_shown = 0; m_pulse = 1;
      end
    end
    m_seg = (m_mode == 1) ? hex_tab[d[4*m_sel +: 4]] : 7'h00;
    if (m_pulse) m_pulse_cnt++;
    @(negedge clk);
    chk("seg_out", seg_out, m_seg);
    chk("sel_idx", sel_idx, m_sel[1:0]);
    chk("switch_pulse", switch_pulse, m_pulse);
    if (switch_pulse) pulse_seen++;
    if (seg_out != 0) sel_seen[sel_idx] = 1'b1;
  endtask

  initial begin
    logic [3:0]  rv;
    logic [15:0] rd;
    logic        rh, re;
    int          guard;
    int          sel_before;
    rst_n = 1'b0; ena = 1'b0; valid = '0; data = '0; hold = 1'b0;
    model_reset();
    m_pulse_cnt = 0; tick_seen = 0; pulse_seen = 0; sel_seen = '0;
    repeat (2) @(negedge clk);
    chk("rst_seg", seg_out, 7'h00);
    chk("rst_sel", sel_idx, 2'd0);
    chk("rst_tick", tick_out, 1'b0);
    chk("rst_pulse", switch_pulse, 1'b0);
    rst_n = 1'b1;

    // Ticks every P cycles, display dark with nothing valid.
    for (int i = 0; i < 12; i++) step(1'b1, 4'b0000, 16'h0000, 1'b0);
    chk("tick_count_12", tick_seen, 3);

    // Two sources alternate with blank gaps.
    pulse_seen = 0; m_pulse_cnt = 0; sel_seen = '0;
    for (int i = 0; i < 48; i++) step(1'b1, 4'b0101, 16'h0305, 1'b0);
    chk("rr_sel_set", sel_seen, 4'b0101);
    chk("rr_pulses", pulse_seen, m_pulse_cnt);

    // Single source: steady, never blanks, one entry pulse.
    pulse_seen = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 4'b0010, 16'h00A0, 1'b0);
    chk("single_pulses", pulse_seen, 1);
    chk("single_seg", seg_out, 7'h77);

    // Hold right after a fresh SHOW entry: selection freezes while ticks continue.
    guard = 0;
    do begin step(1'b1, 4'b0011, 16'h0021, 1'b0); guard++; end while (!switch_pulse && guard < 100);
    chk("hold_entry_found", guard < 100, 1'b1);
    sel_before = sel_idx;
    tick_seen = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0011, 16'h0021, 1'b1);
    chk("hold_sel_frozen", sel_idx, sel_before[1:0]);
    chk("hold_ticks_run", tick_seen, 5);
    for (int i = 0; i < 12; i++) step(1'b1, 4'b0011, 16'h0021, 1'b0);

    // Drop the shown source under hold, then drop everything.
    step(1'b1, 4'b0011 & ~(4'b0001 << sel_idx), 16'h0021, 1'b1);
    step(1'b1, 4'b0011 & ~(4'b0001 << sel_idx), 16'h0021, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 16'h0021, 1'b0);
    chk("drop_idle_seg", seg_out, 7'h00);

    // Live data follows with one cycle latency; then async reset during BLANK.
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1001, 16'h1000 * (i + 1), 1'b0);
    guard = 0;
    while (m_mode != 2 && guard < 200) begin step(1'b1, 4'b1001, 16'h7004, 1'b0); guard++; end
    chk("blank_reached", m_mode == 2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg_out, 7'h00);
    chk("async_rst_sel", sel_idx, 2'd0);
    chk("async_rst_pulse", switch_pulse, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    rv = 4'b1011; rd = 16'hC3A5; rh = 1'b0; re = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rv = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rd = 16'($urandom);
      if ($urandom_range(0, 19) == 0) rh = ~rh;
      re = ($urandom_range(0, 9) != 0);
      step(re, rv, rd, rh);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
